// File: rtl/ws2812_pkg.sv
// Shared types and default 12 MHz timing for the WS2812 serializer.
package ws2812_pkg;

    typedef enum logic [1:0] {LATCH, LOAD, SEND} state_t;

    localparam int PIX_W        = 24;
    localparam int DEF_NUM_LEDS = 8;
    localparam int DEF_T0H      = 4;
    localparam int DEF_T1H      = 8;
    localparam int DEF_T_BIT    = 15;
    localparam int DEF_T_RESET  = 600;

    // LEDs expect green first, then red, then blue, each MSB first.
    function automatic logic [PIX_W-1:0] grb_pack(input logic [7:0] r,
                                                   input logic [7:0] g,
                                                   input logic [7:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812_bit_cell.sv
// One WS2812 bit cell: counts T_BIT clocks and drives the registered line high
// for T0H or T1H of them depending on the bit value.
module ws2812_bit_cell
    import ws2812_pkg::*;
#(
    parameter int T0H   = DEF_T0H,
    parameter int T1H   = DEF_T1H,
    parameter int T_BIT = DEF_T_BIT
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic active,
    input  logic bit_val,
    output logic data_out,
    output logic cell_done
);

    localparam int CW = $clog2(T_BIT);

    logic [CW-1:0] cell_q, cell_d;
    logic [CW-1:0] high_len;
    logic          data_q, data_d;

    always_comb begin
        high_len  = bit_val ? CW'(T1H) : CW'(T0H);
        cell_done = active && (cell_q == CW'(T_BIT - 1));
        cell_d    = cell_q;
        if (start || cell_done) begin
            cell_d = '0;
        end else if (active) begin
            cell_d = cell_q + CW'(1);
        end
        data_d = active && (cell_q < high_len);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cell_q <= '0;
            data_q <= 1'b0;
        end else begin
            cell_q <= cell_d;
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 frame serializer: requests NUM_LEDS pixels per frame over valid/ready,
// shifts each out GRB/MSB-first, then holds the line low for the latch period.
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int T_BIT    = DEF_T_BIT,
    parameter int T_RESET  = DEF_T_RESET,
    localparam int IW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [7:0]    red,
    input  logic [7:0]    green,
    input  logic [7:0]    blue,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic [IW-1:0] led_index,
    output logic          frame_start,
    output logic          busy,
    output logic          data_out
);

    localparam int LW = $clog2(T_RESET + 1);

    state_t             state_q, state_d;
    logic [LW-1:0]      lcnt_q, lcnt_d;
    logic [PIX_W-1:0]   shift_q, shift_d;
    logic [4:0]         bcnt_q, bcnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               fs_q, fs_d;
    logic               cell_start;
    logic               cell_done;

    always_comb begin
        state_d    = state_q;
        lcnt_d     = lcnt_q;
        shift_d    = shift_q;
        bcnt_d     = bcnt_q;
        idx_d      = idx_q;
        fs_d       = 1'b0;
        pix_ready  = 1'b0;
        busy       = 1'b0;
        cell_start = 1'b0;
        case (state_q)
            LATCH: begin
                if (lcnt_q == LW'(T_RESET - 1)) begin
                    state_d = LOAD;
                    lcnt_d  = '0;
                    idx_d   = '0;
                    fs_d    = 1'b1;
                end else begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end
            LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    shift_d    = grb_pack(red, green, blue);
                    bcnt_d     = 5'(PIX_W - 1);
                    cell_start = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                busy = 1'b1;
                if (cell_done) begin
                    shift_d = {shift_q[PIX_W-2:0], 1'b0};
                    bcnt_d  = bcnt_q - 5'd1;
                    // Last bit of this pixel: either fetch the next LED or latch the frame.
                    if (bcnt_q == 5'd0) begin
                        if (idx_q == IW'(NUM_LEDS - 1)) begin
                            idx_d   = '0;
                            lcnt_d  = '0;
                            state_d = LATCH;
                        end else begin
                            idx_d   = idx_q + IW'(1);
                            state_d = LOAD;
                        end
                    end
                end
            end
            default: state_d = LATCH;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= LATCH;
            lcnt_q  <= '0;
            shift_q <= '0;
            bcnt_q  <= '0;
            idx_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            fs_q    <= fs_d;
        end
    end

    ws2812_bit_cell #(
        .T0H   (T0H),
        .T1H   (T1H),
        .T_BIT (T_BIT)
    ) u_cell (
        .clk       (clk),
        .resetn    (resetn),
        .start     (cell_start),
        .active    (busy),
        .bit_val   (shift_q[PIX_W-1]),
        .data_out  (data_out),
        .cell_done (cell_done)
    );

    assign led_index   = idx_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench: a default 2-LED instance and a fast-timing 1-LED instance,
// decoding the data line and checking timing against hand-computed values.
module tb_ws2812_tx;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sel;

    // Instance A: NUM_LEDS=2, default timing
    logic [7:0]  red_a, green_a, blue_a;
    logic        valid_a, ready_a, fs_a, busy_a, data_out_a;
    logic [0:0]  led_index_a;
    logic [23:0] px_tab [0:1];

    // Instance B: NUM_LEDS=1, T0H=2, T1H=5, T_BIT=8
    logic [7:0]  red_b, green_b, blue_b;
    logic        valid_b, ready_b, fs_b, busy_b, data_out_b;
    logic [0:0]  led_index_b;

    int total = 0;
    int bad   = 0;

    int hi_arr  [0:23];
    int per_arr [0:23];

    int cyc = 0, busy_run = 0, last_busy = 0, fs_last = 0, fs_prev = 0;

    always #5 clk = ~clk;

    assign {red_a, green_a, blue_a} = px_tab[led_index_a];
    assign red_b   = 8'h00;
    assign green_b = 8'hA5;
    assign blue_b  = 8'hC3;
    assign valid_b = 1'b1;

    wire dmux  = sel ? data_out_b : data_out_a;
    wire fsmux = sel ? fs_b : fs_a;

    ws2812_tx #(.NUM_LEDS(2)) dut_a (
        .clk(clk), .resetn(resetn), .red(red_a), .green(green_a), .blue(blue_a),
        .pix_valid(valid_a), .pix_ready(ready_a), .led_index(led_index_a),
        .frame_start(fs_a), .busy(busy_a), .data_out(data_out_a)
    );

    ws2812_tx #(.NUM_LEDS(1), .T0H(2), .T1H(5), .T_BIT(8)) dut_b (
        .clk(clk), .resetn(resetn), .red(red_b), .green(green_b), .blue(blue_b),
        .pix_valid(valid_b), .pix_ready(ready_b), .led_index(led_index_b),
        .frame_start(fs_b), .busy(busy_b), .data_out(data_out_b)
    );

    // Instance A busy-run length and frame_start timestamps, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (busy_a) begin
            busy_run++;
        end else begin
            if (busy_run > 0) last_busy = busy_run;
            busy_run = 0;
        end
        if (fs_a) begin
            fs_prev = fs_last;
            fs_last = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            $display("ok   %s: %0d (0x%0h)", tag, got, got);
        end
    endtask

    task automatic wait_fs(input int lim, output int n, output int highs);
        n = 0;
        highs = 0;
        do begin
            @(negedge clk);
            n++;
            if (dmux) highs++;
        end while (!fsmux && n < lim);
    endtask

    // Decode 24 cells from the selected line; must be called with the line low.
    task automatic rx_pixel(output logic [23:0] w, output int ok);
        int hi, per, n, thr;
        ok  = 1;
        w   = '0;
        thr = sel ? 2 : 4;
        for (int b = 0; b < 24; b++) begin
            n = 0;
            while (!dmux && n < 5000) begin @(negedge clk); n++; end
            if (n >= 5000) begin ok = 0; return; end
            hi = 0;
            while (dmux && hi < 100) begin @(negedge clk); hi++; end
            per = hi;
            if (b < 23) while (!dmux && per < 100) begin @(negedge clk); per++; end
            hi_arr[b]  = hi;
            per_arr[b] = per;
            w = {w[22:0], (hi > thr)};
        end
    endtask

    task automatic check_cells(input logic [23:0] exp, input int t0, input int t1, input int tbit);
        for (int b = 0; b < 24; b++) begin
            check($sformatf("cell_hi[%0d]", b), hi_arr[b], exp[23-b] ? t1 : t0);
            if (b < 23) check($sformatf("cell_per[%0d]", b), per_arr[b], tbit);
        end
    endtask

    initial begin
        logic [23:0] w;
        int ok, n, highs, nrdy, nidx;

        sel     = 1'b0;
        resetn  = 1'b0;
        valid_a = 1'b1;
        px_tab[0] = 24'h00FF00;
        px_tab[1] = 24'h5A0F81;
        repeat (3) @(negedge clk);

        check("rst_data_out",    32'(data_out_a),  0);
        check("rst_pix_ready",   32'(ready_a),     0);
        check("rst_busy",        32'(busy_a),      0);
        check("rst_frame_start", 32'(fs_a),        0);
        check("rst_led_index",   32'(led_index_a), 0);

        resetn = 1'b1;
        wait_fs(2000, n, highs);
        check("latch_len",       n, 600);
        check("latch_highs",     highs, 0);
        check("fs_pix_ready",    32'(ready_a), 1);
        check("fs_led_index",    32'(led_index_a), 0);
        @(negedge clk);
        check("fs_one_cycle",    32'(fs_a), 0);

        // Frame 1: LED0 green only, LED1 R=5A G=0F B=81
        rx_pixel(w, ok);
        check("f1_led0_rx_ok",   ok, 1);
        check("f1_led0_word",    32'(w), 32'h00FF0000);
        check_cells(24'hFF0000, 4, 8, 15);
        check("f1_led0_index",   32'(led_index_a), 0);
        n = 0;
        while (busy_a && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        check("f1_led0_busy_len", last_busy, 360);
        rx_pixel(w, ok);
        check("f1_led1_rx_ok",   ok, 1);
        check("f1_led1_word",    32'(w), 32'h000F5A81);
        check("f1_led1_index",   32'(led_index_a), 1);
        px_tab[0] = 24'h123456;
        px_tab[1] = 24'hABCDEF;
        wait_fs(2000, n, highs);
        check("f1_tail_latch",   n, 606);
        check("f1_tail_highs",   highs, 0);
        check("f2_fs_index",     32'(led_index_a), 0);

        // Frame 2: 0x123456, 0xABCDEF with valid held
        @(negedge clk);
        rx_pixel(w, ok);
        check("f2_led0_word",    32'(w), 32'h00341256);
        check("f2_led0_index",   32'(led_index_a), 0);
        rx_pixel(w, ok);
        check("f2_led1_word",    32'(w), 32'h00CDABEF);
        check("f2_led1_index",   32'(led_index_a), 1);
        px_tab[0] = 24'h112233;
        px_tab[1] = 24'hC0FF01;
        wait_fs(2000, n, highs);
        check("f2_tail_latch",   n, 606);
        check("f2_frame_period", fs_last - fs_prev, 1322);

        // Frame 3: 100-clock stall in LOAD before LED1
        @(negedge clk);
        rx_pixel(w, ok);
        check("f3_led0_word",    32'(w), 32'h00221133);
        valid_a = 1'b0;
        n = 0;
        while (!ready_a && n < 100) begin @(negedge clk); n++; end
        check("stall_ready_seen", 32'(ready_a), 1);
        highs = 0; nrdy = 0; nidx = 0;
        repeat (100) begin
            @(negedge clk);
            if (data_out_a) highs++;
            if (!ready_a) nrdy++;
            if (led_index_a != 1'b1) nidx++;
        end
        check("stall_highs",     highs, 0);
        check("stall_ready_lost", nrdy, 0);
        check("stall_index_bad", nidx, 0);
        valid_a = 1'b1;
        rx_pixel(w, ok);
        check("f3_led1_rx_ok",   ok, 1);
        check("f3_led1_word",    32'(w), 32'h00FFC001);
        wait_fs(2000, n, highs);
        check("f3_tail_latch",   n, 606);
        check("f3_frame_period", fs_last - fs_prev, 1422);

        // Frame 4: reset asserted mid-high during LED0
        n = 0;
        while (!data_out_a && n < 2000) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check("pre_rst_high",    32'(data_out_a), 1);
        resetn = 1'b0;
        #1;
        check("mid_rst_data_out",  32'(data_out_a),  0);
        check("mid_rst_led_index", 32'(led_index_a), 0);
        check("mid_rst_busy",      32'(busy_a),      0);
        check("mid_rst_ready",     32'(ready_a),     0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wait_fs(2000, n, highs);
        check("post_rst_latch",  n, 600);
        check("post_rst_highs",  highs, 0);
        @(negedge clk);
        rx_pixel(w, ok);
        check("post_rst_word",   32'(w), 32'h00221133);

        // Instance B: fast timing, single LED per frame
        sel = 1'b1;
        wait_fs(2000, n, highs);
        check("b_fs_seen",       32'(fs_b), 1);
        @(negedge clk);
        rx_pixel(w, ok);
        check("b_rx_ok",         ok, 1);
        check("b_word",          32'(w), 32'h00A500C3);
        check_cells(24'hA500C3, 2, 5, 8);
        check("b_index",         32'(led_index_b), 0);
        wait_fs(2000, n, highs);
        check("b_tail_latch",    n, 602);
        check("b_tail_highs",    highs, 0);
        check("b_fs_ready",      32'(ready_b), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ws2812_tx.md
Name: ws2812_tx

Overview:
- Downstream serializer for the colour-wheel stage.
- Accepts one 24-bit RGB pixel per LED over a valid/ready handshake and emits the single-wire WS2812 NRZ bit stream, GRB order, MSB first.
- After NUM_LEDS pixels it holds the line low for the latch/reset period, then requests the next frame.
- It also exports the index of the LED it wants, so upstream can derive a per-LED wheel position.

Parameters:
- NUM_LEDS, 8: LEDs per frame, must be >= 1.
- T0H, 4: clocks high for a 0 bit (0.35 us at 12 MHz).
- T1H, 8: clocks high for a 1 bit (0.7 us at 12 MHz).
- T_BIT, 15: total clocks per bit cell (1.25 us at 12 MHz). Requires T0H < T1H < T_BIT.
- T_RESET, 600: clocks of low latch time between frames (50 us at 12 MHz).

Ports:
- clk, input, 1: system clock.
- resetn, input, 1: asynchronous active-low reset.
- red, input, 8: pixel red component.
- green, input, 8: pixel green component.
- blue, input, 8: pixel blue component.
- pix_valid, input, 1: upstream presents a pixel.
- pix_ready, output, 1: block accepts a pixel this cycle.
- led_index, output, max(1,$clog2(NUM_LEDS)): index of the LED being requested or sent.
- frame_start, output, 1: one-cycle pulse when the first pixel of a frame is requested.
- busy, output, 1: high while a pixel is shifting out.
- data_out, output, 1: registered WS2812 data line.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset resetn is asynchronous, active-low.
  - Reset forces: data_out=0, pix_ready=0, busy=0, frame_start=0, led_index=0, state=LATCH, latch counter=0.
  - Reset mid-frame abandons the current pixel and restarts with a full T_RESET latch.
- State LATCH:
  - data_out=0. Counter runs 0..T_RESET-1.
  - At T_RESET-1: go to LOAD, pulse frame_start for one cycle (coincident with the first LOAD cycle), led_index=0.
- State LOAD:
  - pix_ready=1, data_out=0.
  - On pix_valid&pix_ready: capture shift={green,red,blue}, bit counter=23, cell counter=0, go to SEND.
  - pix_valid low holds LOAD indefinitely with the line low. Stalls >= T_RESET clocks mid-frame will latch the LEDs; avoiding that is upstream's responsibility and is not detected.
  - Inputs are sampled only on the handshake cycle.
- State SEND:
  - busy=1, pix_ready=0.
  - Cell counter runs 0..T_BIT-1. data_out is registered and equals (cell < (shift[23] ? T1H : T0H)).
  - At cell=T_BIT-1: shift left by 1 and decrement the bit counter.
  - After bit 0 completes:
    - If led_index==NUM_LEDS-1: led_index=0, go to LATCH with counter=0.
    - Otherwise: led_index+1, go to LOAD.
- Latency and timing:
  - Handshake at edge N puts data_out high starting after edge N+1.
  - Each pixel occupies exactly 24*T_BIT clocks of SEND.
  - With pix_valid held high, each inter-pixel LOAD adds exactly one low clock to the previous pixel's last bit.
- Frame period with valid always high: NUM_LEDS*(24*T_BIT+1) + T_RESET clocks.
- led_index holds stable from the LOAD cycle through the end of SEND for that pixel.

Decomposition:
- Package ws2812_pkg:
  - State enum {LATCH, LOAD, SEND}.
  - Default timing constants for 12 MHz.
  - Pixel width constant 24.
  - A function giving the GRB packing order.
- One sub-module, ws2812_bit_cell:
  - Inputs: start, bit value.
  - Owns the cell counter and high-time compare.
  - Outputs: data_out and cell_done.
- The top level owns the FSM, shift register, bit counter and LED index.

Test Plan:
- Reset then idle (NUM_LEDS=2, defaults):
  - data_out stays 0 for 600 clocks, then frame_start pulses once with pix_ready=1 and led_index=0.
- Send pixel R=0x00, G=0xFF, B=0x00, valid held:
  - First 8 bit cells are high 8/low 7, next 16 cells are high 4/low 11.
  - busy is high for exactly 360 clocks.
- Two-LED frame with valid always high, pixels 0x123456 and 0xABCDEF:
  - Decoded stream is 0x341256 then 0xCDABEF.
  - led_index sequence 0,1, then 600 low clocks, then frame_start again.
  - Frame period is 2*361+600 = 1322 clocks.
- Stall: pix_valid low for 100 clocks in LOAD before LED1:
  - Line stays low for those 100 clocks, no data is lost, and the LED1 stream is correct after valid rises.
- Async reset asserted mid-bit during SEND of LED0:
  - data_out drops to 0 immediately, led_index=0, and the full 600-clock latch elapses before frame_start.
- Parameter sweep T0H=2, T1H=5, T_BIT=8, NUM_LEDS=1:
  - Bit cell high times are 2/5 and the period is 8.
  - After every pixel the block enters LATCH.
